// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter and its helpers.
//   state_e      : arbiter FSM encoding (IDLE/ISSUE/WAIT/RESP)
//   TIMEOUT_DEF  : default watchdog limit, in WAIT cycles
//   CNT_W_DEF    : default watchdog counter width
//   ID_ALU/ID_AGU: requester identifiers carried on rsp_id
package mul_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int unsigned TIMEOUT_DEF = 40;
  localparam int unsigned CNT_W_DEF   = 6;

  localparam logic ID_ALU = 1'b0;
  localparam logic ID_AGU = 1'b1;

endpackage

// File: rtl/mul_sign_fix.sv
// Combinational sign handling around an unsigned 16x16 multiplier.
//   a_i, b_i   : raw operands
//   sgn_i      : 1 = operands are two's-complement signed
//   a_mag_o    : |a_i| when signed, else a_i (|-32768| = 0x8000 unsigned)
//   b_mag_o    : |b_i| when signed, else b_i
//   prod_i     : unsigned 32-bit product
//   neg_i      : 1 = negate the product
//   prod_o     : prod_i, two's-complement negated when neg_i
module mul_sign_fix (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sgn_i,
  output logic [15:0] a_mag_o,
  output logic [15:0] b_mag_o,
  input  logic [31:0] prod_i,
  input  logic        neg_i,
  output logic [31:0] prod_o
);

  logic [15:0] op_in  [2];
  logic [15:0] op_mag [2];

  assign op_in[0] = a_i;
  assign op_in[1] = b_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_abs
      // Negating 0x8000 wraps back to 0x8000, which read as unsigned is
      // exactly the magnitude we want.
      assign op_mag[gi] = (sgn_i && op_in[gi][15]) ? (~op_in[gi] + 16'd1)
                                                   : op_in[gi];
    end
  endgenerate

  assign a_mag_o = op_mag[0];
  assign b_mag_o = op_mag[1];

  assign prod_o = neg_i ? (~prod_i + 32'd1) : prod_i;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end sharing one shift-add unsigned 16x16 multiplier
// between the ALU execute stage (requester 0) and the AGU (requester 1).
//   clk, rst            : clock, synchronous active-high reset
//   reqN/aN/bN/sgnN     : level request with operands and signed flag
//   ackN                : one-cycle accept pulse, operands latched
//   rsp_valid           : one-cycle result pulse
//   rsp_id/err/hi/lo    : requester, watchdog error, 32-bit product
//   busy                : FSM not in IDLE
//   mul_start/a/b       : start pulse and operand magnitudes to multiplier
//   mul_done/hi/lo      : multiplier completion and unsigned product
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic        sgn0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic        sgn1,
  output logic        ack1,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [15:0] rsp_hi,
  output logic [15:0] rsp_lo,
  output logic        busy,
  output logic        mul_start,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic        mul_done,
  input  logic [15:0] mul_hi,
  input  logic [15:0] mul_lo
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_e state_q, state_d;

  logic             last_gnt_q, last_gnt_d;
  logic             id_q, id_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             mul_start_q, mul_start_d;
  logic [15:0]      mul_a_q, mul_a_d;
  logic [15:0]      mul_b_q, mul_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;
  logic [15:0]      rsp_hi_q, rsp_hi_d;
  logic [15:0]      rsp_lo_q, rsp_lo_d;
  logic             busy_q, busy_d;

  // Arbitration: a lone request wins outright; on a tie the requester that
  // did not win last time gets the grant.
  logic        any_req;
  logic        gnt;
  logic [15:0] a_sel, b_sel;
  logic        sgn_sel;
  logic [15:0] a_mag, b_mag;
  logic [31:0] prod_fix;
  logic [CNT_W-1:0] wdog_inc;
  logic        timeout_hit;

  assign any_req = req0 | req1;
  assign gnt     = (req0 && req1) ? ~last_gnt_q : req1;
  assign a_sel   = gnt ? a1 : a0;
  assign b_sel   = gnt ? b1 : b0;
  assign sgn_sel = gnt ? sgn1 : sgn0;

  assign wdog_inc    = wdog_q + CNT_W'(1);
  assign timeout_hit = (wdog_inc == TIMEOUT_CNT);

  mul_sign_fix u_sign_fix (
    .a_i     (a_sel),
    .b_i     (b_sel),
    .sgn_i   (sgn_sel),
    .a_mag_o (a_mag),
    .b_mag_o (b_mag),
    .prod_i  ({mul_hi, mul_lo}),
    .neg_i   (neg_q),
    .prod_o  (prod_fix)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mul_done || timeout_hit) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values. Every output is registered, so each
  // pulse is scheduled on the transition into the state it belongs to:
  // ack shows during ISSUE, mul_start during the first WAIT cycle and
  // rsp_valid during RESP.
  always_comb begin
    last_gnt_d  = last_gnt_q;
    id_d        = id_q;
    neg_d       = neg_q;
    wdog_d      = wdog_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_lo_d    = rsp_lo_q;
    busy_d      = (state_d != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          ack0_d     = (gnt == ID_ALU);
          ack1_d     = (gnt == ID_AGU);
          id_d       = gnt;
          neg_d      = sgn_sel & (a_sel[15] ^ b_sel[15]);
          mul_a_d    = a_mag;
          mul_b_d    = b_mag;
          last_gnt_d = gnt;
        end
      end
      ST_ISSUE: begin
        mul_start_d = 1'b1;
        wdog_d      = '0;
      end
      ST_WAIT: begin
        if (mul_done) begin
          rsp_valid_d          = 1'b1;
          rsp_id_d             = id_q;
          rsp_err_d            = 1'b0;
          {rsp_hi_d, rsp_lo_d} = prod_fix;
        end else if (timeout_hit) begin
          rsp_valid_d          = 1'b1;
          rsp_id_d             = id_q;
          rsp_err_d            = 1'b1;
          {rsp_hi_d, rsp_lo_d} = '0;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q  <= ID_AGU;
      id_q        <= 1'b0;
      neg_q       <= 1'b0;
      wdog_q      <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      id_q        <= id_d;
      neg_q       <= neg_d;
      wdog_q      <= wdog_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_lo_q    <= rsp_lo_d;
      busy_q      <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;
  localparam int LAT     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, sgn0, req1, sgn1;
  logic [15:0] a0, b0, a1, b1;
  logic        ack0, ack1;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [15:0] rsp_hi, rsp_lo;
  logic        busy, mul_start, mul_done;
  logic [15:0] mul_a, mul_b, mul_hi, mul_lo;

  logic        mdl_en, mdl_done, inj_done;
  logic [15:0] mdl_hi, mdl_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mul_done = mdl_done | inj_done;
  assign mul_hi   = mdl_hi;
  assign mul_lo   = mdl_lo;

  mul_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .sgn0(sgn0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .sgn1(sgn1), .ack1(ack1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo)
  );

  // Behavioural shift-add multiplier: fixed latency from the start pulse.
  initial begin
    logic [31:0] prod;
    mdl_done = 1'b0;
    mdl_hi   = '0;
    mdl_lo   = '0;
    forever begin
      @(posedge clk); #1;
      if (mul_start && mdl_en) begin
        prod = 32'(mul_a) * 32'(mul_b);
        repeat (LAT) @(posedge clk);
        #1;
        {mdl_hi, mdl_lo} = prod;
        mdl_done = 1'b1;
        @(posedge clk); #1;
        mdl_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},   {30'd0, ack1, ack0}, 32'd0);
    check({tag, "_rsp"},   {29'd0, rsp_valid, rsp_id, rsp_err}, 32'd0);
    check({tag, "_data"},  {rsp_hi, rsp_lo}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_start"}, {31'd0, mul_start}, 32'd0);
    check({tag, "_mulab"}, {mul_a, mul_b}, 32'd0);
  endtask

  // One solo request from IDLE through its response.
  task automatic do_op(input logic rid, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] ema, input logic [15:0] emb,
                       input logic [31:0] eres);
    int cyc;
    if (rid == 1'b0) begin a0 = a; b0 = b; sgn0 = s; req0 = 1'b1; end
    else             begin a1 = a; b1 = b; sgn1 = s; req1 = 1'b1; end
    cyc = 0;
    do begin tick(); cyc++; end while (!(rid ? ack1 : ack0) && cyc < 50);
    check("ack_lat", cyc, 1);
    check("ack_other", {31'd0, rid ? ack0 : ack1}, 32'd0);
    check("busy", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("start", {31'd0, mul_start}, 32'd1);
    check("mul_ab", {mul_a, mul_b}, {ema, emb});
    tick();
    check("start_pulse", {31'd0, mul_start}, 32'd0);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin tick(); cyc++; end
    check("rsp_lat", cyc, LAT);
    check("rsp_id", {31'd0, rsp_id}, {31'd0, rid});
    check("rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rsp_data", {rsp_hi, rsp_lo}, eres);
    $display("op id=%0d a=%h b=%h sgn=%0d -> %h", rid, a, b, s, {rsp_hi, rsp_lo});
    tick();
    check("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    check("rsp_hold", {rsp_hi, rsp_lo}, eres);
  endtask

  // Both requesters active; each drops req the cycle after ack and
  // re-raises it the following cycle while it still has work.
  task automatic run_both(input int n0, input int n1, input logic [3:0] exp_order);
    logic [31:0] exp0 = 32'h0000_4E20;
    logic [31:0] exp1 = 32'hFFFF_B1E0;
    int r0 = n0;
    int r1 = n1;
    int got = 0;
    int cyc = 0;
    logic re0 = 1'b0;
    logic re1 = 1'b0;
    a0 = 16'd100;    b0 = 16'd200; sgn0 = 1'b0;
    a1 = 16'hFF9C;   b1 = 16'd200; sgn1 = 1'b1;
    req0 = (r0 > 0);
    req1 = (r1 > 0);
    while (got < n0 + n1 && cyc < 2000) begin
      tick();
      cyc++;
      if (re0) begin req0 = 1'b1; re0 = 1'b0; end
      if (re1) begin req1 = 1'b1; re1 = 1'b0; end
      if (ack0) begin req0 = 1'b0; r0--; re0 = (r0 > 0); end
      if (ack1) begin req1 = 1'b0; r1--; re1 = (r1 > 0); end
      if (rsp_valid) begin
        check("arb_id", {31'd0, rsp_id}, {31'd0, exp_order[got]});
        check("arb_data", {rsp_hi, rsp_lo}, exp_order[got] ? exp1 : exp0);
        check("arb_err", {31'd0, rsp_err}, 32'd0);
        $display("arb rsp %0d id=%0d data=%h", got, rsp_id, {rsp_hi, rsp_lo});
        got++;
      end
    end
    check("arb_count", got, n0 + n1);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    req0 = 1'b0; a0 = '0; b0 = '0; sgn0 = 1'b0;
    req1 = 1'b0; a1 = '0; b1 = '0; sgn1 = 1'b0;
    mdl_en = 1'b1;
    inj_done = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // Simultaneous requests straight after reset: requester 0 first.
    run_both(1, 1, 4'b0010);

    do_op(1'b0, 16'd3,    16'd5,    1'b0, 16'd3,    16'd5,    32'h0000_000F);
    do_op(1'b1, 16'hFFFD, 16'd5,    1'b1, 16'd3,    16'd5,    32'hFFFF_FFF1);
    do_op(1'b0, 16'h8000, 16'h8000, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
    do_op(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h8000, 16'h8000, 32'h4000_0000);
    do_op(1'b1, 16'd7,    16'hFFF7, 1'b1, 16'd7,    16'd9,    32'hFFFF_FFC1);

    // Requester 1 won last: continuous contention alternates 0,1,0,1.
    run_both(2, 2, 4'b1010);
    // Requester 0 won last: make it alternate starting with 1.
    do_op(1'b0, 16'd2, 16'd2, 1'b0, 16'd2, 16'd2, 32'h0000_0004);
    run_both(2, 2, 4'b0101);

    // Watchdog: multiplier never answers.
    mdl_en = 1'b0;
    a0 = 16'd1; b0 = 16'd1; sgn0 = 1'b0; req0 = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!ack0 && cyc < 50);
    check("to_ack", {31'd0, ack0}, 32'd1);
    req0 = 1'b0;
    tick();
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin tick(); cyc++; end
    check("to_lat", cyc, TIMEOUT);
    check("to_err", {31'd0, rsp_err}, 32'd1);
    check("to_data", {rsp_hi, rsp_lo}, 32'd0);
    check("to_id", {31'd0, rsp_id}, 32'd0);
    $display("timeout after %0d cycles err=%0d", cyc, rsp_err);
    tick();

    // Reset during WAIT, then a stale done pulse in IDLE.
    a1 = 16'd5; b1 = 16'd6; sgn1 = 1'b0; req1 = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!ack1 && cyc < 50);
    check("rw_ack", {31'd0, ack1}, 32'd1);
    req1 = 1'b0;
    repeat (5) tick();
    check("rw_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outputs_zero("rw_reset");
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid || busy) cyc++;
      tick();
    end
    check("stale_done", cyc, 0);
    $display("reset mid-op, stale done ignored");
    mdl_en = 1'b1;
    do_op(1'b0, 16'd7, 16'd9, 1'b0, 16'd7, 16'd9, 32'h0000_003F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
